// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the CPU/GP memory port arbiter.
package mem_arb_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    CPU_ISSUE = 3'd1,
    CPU_WAIT  = 3'd2,
    GP_ISSUE  = 3'd3,
    GP_WAIT   = 3'd4
  } arb_state_t;

  localparam logic [3:0] WE_NONE = 4'b0000;

endpackage

// File: rtl/arb_age_counter.sv
// Saturating wait counter for a requester that loses arbitration.
// Raises starved once the requester has waited MAX_WAIT cycles.
module arb_age_counter #(
  parameter int MAX_WAIT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic waiting,
  input  logic granted,
  output logic starved
);

  localparam int W = $clog2(MAX_WAIT + 1);
  localparam logic [W-1:0] SAT = W'(MAX_WAIT);

  logic [W-1:0] count;

  // Count cycles spent requesting without a grant; saturate so the flag holds.
  always_ff @(posedge clk) begin
    if (rst)                      count <= '0;
    else if (!waiting || granted) count <= '0;
    else if (count != SAT)        count <= count + W'(1);
  end

  assign starved = (count >= SAT);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory request port between CPU data traffic and GP burst reads.
// CPU wins by default; a starved GP wins the next arbitration.
//
// state     | meaning
// IDLE      | no transaction; arbitrate and latch the winner
// CPU_ISSUE | CPU request on mem port, waiting for mem_req_ready
// CPU_WAIT  | CPU read issued, waiting for the single response beat
// GP_ISSUE  | GP burst request on mem port, waiting for mem_req_ready
// GP_WAIT   | GP burst issued, forwarding BURST_LEN beats
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int BURST_LEN   = 8,
  parameter int GP_MAX_WAIT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_req_valid,
  output logic        cpu_req_ready,
  input  logic [31:0] cpu_req_addr,
  input  logic [3:0]  cpu_req_we,
  input  logic [31:0] cpu_req_wdata,
  output logic        cpu_resp_valid,
  output logic [31:0] cpu_resp_data,
  input  logic        gp_req_valid,
  output logic        gp_req_ready,
  input  logic [31:0] gp_req_addr,
  output logic        gp_resp_valid,
  output logic [31:0] gp_resp_data,
  output logic        gp_resp_last,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [31:0] mem_req_addr,
  output logic [3:0]  mem_req_we,
  output logic [31:0] mem_req_wdata,
  output logic        mem_req_burst,
  input  logic        mem_resp_valid,
  input  logic [31:0] mem_resp_data
);

  localparam int BW = $clog2(BURST_LEN);
  localparam logic [BW-1:0] LAST_BEAT = BW'(BURST_LEN - 1);

  arb_state_t    state, state_next;
  logic [31:0]   lat_addr, lat_wdata;
  logic [3:0]    lat_we;
  logic [BW-1:0] beat_cnt;
  logic          gp_starved, gp_win, cpu_win, last_beat;

  assign gp_win    = (state == IDLE) & gp_req_valid & (gp_starved | ~cpu_req_valid);
  assign cpu_win   = (state == IDLE) & cpu_req_valid & ~gp_win;
  assign last_beat = (beat_cnt == LAST_BEAT);

  arb_age_counter #(.MAX_WAIT(GP_MAX_WAIT)) u_age (
    .clk     (clk),
    .rst     (rst),
    .waiting (gp_req_valid),
    .granted (gp_win),
    .starved (gp_starved)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Request latch: captures the arbitration winner on the IDLE->ISSUE edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      lat_addr  <= '0;
      lat_we    <= WE_NONE;
      lat_wdata <= '0;
    end else if (gp_win) begin
      lat_addr  <= gp_req_addr;
      lat_we    <= WE_NONE;
      lat_wdata <= '0;
    end else if (cpu_win) begin
      lat_addr  <= cpu_req_addr;
      lat_we    <= cpu_req_we;
      lat_wdata <= cpu_req_wdata;
    end
  end

  // Burst beat counter; wraps to zero on the final beat.
  always_ff @(posedge clk) begin
    if (rst)                beat_cnt <= '0;
    else if (gp_resp_valid) beat_cnt <= last_beat ? '0 : beat_cnt + BW'(1);
  end

  // Next-state logic, memory request drive and response steering.
  always_comb begin
    state_next     = state;
    cpu_req_ready  = 1'b0;
    gp_req_ready   = 1'b0;
    mem_req_valid  = 1'b0;
    mem_req_addr   = '0;
    mem_req_we     = WE_NONE;
    mem_req_wdata  = '0;
    mem_req_burst  = 1'b0;
    cpu_resp_valid = 1'b0;
    cpu_resp_data  = '0;
    gp_resp_valid  = 1'b0;
    gp_resp_data   = '0;
    gp_resp_last   = 1'b0;
    case (state)
      IDLE: begin
        cpu_req_ready = cpu_win;
        gp_req_ready  = gp_win;
        if (gp_win)       state_next = GP_ISSUE;
        else if (cpu_win) state_next = CPU_ISSUE;
      end
      CPU_ISSUE: begin
        mem_req_valid = 1'b1;
        mem_req_addr  = lat_addr;
        mem_req_we    = lat_we;
        mem_req_wdata = lat_wdata;
        if (mem_req_ready) state_next = (lat_we != WE_NONE) ? IDLE : CPU_WAIT;
      end
      CPU_WAIT: begin
        cpu_resp_valid = mem_resp_valid;
        if (mem_resp_valid) begin
          cpu_resp_data = mem_resp_data;
          state_next    = IDLE;
        end
      end
      GP_ISSUE: begin
        mem_req_valid = 1'b1;
        mem_req_addr  = lat_addr;
        mem_req_burst = 1'b1;
        if (mem_req_ready) state_next = GP_WAIT;
      end
      GP_WAIT: begin
        gp_resp_valid = mem_resp_valid;
        if (mem_resp_valid) begin
          gp_resp_data = mem_resp_data;
          gp_resp_last = last_beat;
          if (last_beat) state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios with literal expectations,
// then randomized traffic against a transaction-level model checked every cycle.
module tb_mem_port_arbiter;

  localparam int BURST_LEN   = 8;
  localparam int GP_MAX_WAIT = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_req_valid, cpu_req_ready;
  logic [31:0] cpu_req_addr, cpu_req_wdata, cpu_resp_data;
  logic [3:0]  cpu_req_we;
  logic        cpu_resp_valid;
  logic        gp_req_valid, gp_req_ready;
  logic [31:0] gp_req_addr, gp_resp_data;
  logic        gp_resp_valid, gp_resp_last;
  logic        mem_req_valid, mem_req_ready, mem_req_burst;
  logic [31:0] mem_req_addr, mem_req_wdata;
  logic [3:0]  mem_req_we;
  logic        mem_resp_valid;
  logic [31:0] mem_resp_data;

  mem_port_arbiter #(.BURST_LEN(BURST_LEN), .GP_MAX_WAIT(GP_MAX_WAIT)) dut (
    .clk(clk), .rst(rst),
    .cpu_req_valid(cpu_req_valid), .cpu_req_ready(cpu_req_ready),
    .cpu_req_addr(cpu_req_addr), .cpu_req_we(cpu_req_we), .cpu_req_wdata(cpu_req_wdata),
    .cpu_resp_valid(cpu_resp_valid), .cpu_resp_data(cpu_resp_data),
    .gp_req_valid(gp_req_valid), .gp_req_ready(gp_req_ready), .gp_req_addr(gp_req_addr),
    .gp_resp_valid(gp_resp_valid), .gp_resp_data(gp_resp_data), .gp_resp_last(gp_resp_last),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
    .mem_req_we(mem_req_we), .mem_req_wdata(mem_req_wdata), .mem_req_burst(mem_req_burst),
    .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data)
  );

  always #5 clk = ~clk;

  logic [6:0] ctrl_act;
  assign ctrl_act = {cpu_req_ready, gp_req_ready, mem_req_valid, mem_req_burst,
                     cpu_resp_valid, gp_resp_valid, gp_resp_last};

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0b, expected %0b at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: which requester owns the port, whether its
  // request has been accepted, how many beats remain, how long the GP waited.
  int          m_cur;      // 0 none, 1 cpu, 2 gp
  bit          m_issued;
  int          m_left;
  int          m_waited;
  logic [31:0] m_addr, m_wdata;
  logic [3:0]  m_we;
  bit          m_known = 1'b0;

  logic        e_crdy, e_grdy, e_mv, e_burst, e_cv, e_gv, e_last;
  logic [31:0] e_addr, e_wd, e_cd, e_gd;
  logic [3:0]  e_we;

  task automatic model_expect();
    bit gp_wins;
    e_crdy = 0; e_grdy = 0; e_mv = 0; e_burst = 0; e_cv = 0; e_gv = 0; e_last = 0;
    e_addr = 0; e_wd = 0; e_cd = 0; e_gd = 0; e_we = 0;
    if (m_cur == 0) begin
      gp_wins = gp_req_valid && (m_waited >= GP_MAX_WAIT || !cpu_req_valid);
      e_grdy  = gp_wins;
      e_crdy  = cpu_req_valid && !gp_wins;
    end else if (!m_issued) begin
      e_mv    = 1;
      e_addr  = m_addr;
      e_burst = (m_cur == 2);
      if (m_cur == 1) begin
        e_we = m_we;
        e_wd = m_wdata;
      end
    end else if (m_cur == 1) begin
      e_cv = mem_resp_valid;
      if (mem_resp_valid) e_cd = mem_resp_data;
    end else begin
      e_gv = mem_resp_valid;
      if (mem_resp_valid) begin
        e_gd   = mem_resp_data;
        e_last = (m_left == 1);
      end
    end
  endtask

  task automatic model_step();
    if (rst) begin
      m_cur = 0; m_issued = 0; m_left = 0; m_waited = 0;
      m_addr = 0; m_wdata = 0; m_we = 0; m_known = 1;
    end else begin
      if (gp_req_valid && !e_grdy)
        m_waited = (m_waited < GP_MAX_WAIT) ? m_waited + 1 : GP_MAX_WAIT;
      else
        m_waited = 0;
      if (m_cur == 0) begin
        if (e_grdy) begin
          m_cur = 2; m_issued = 0; m_left = BURST_LEN;
          m_addr = gp_req_addr; m_we = 0; m_wdata = 0;
        end else if (e_crdy) begin
          m_cur = 1; m_issued = 0;
          m_addr = cpu_req_addr; m_we = cpu_req_we; m_wdata = cpu_req_wdata;
        end
      end else if (!m_issued) begin
        if (mem_req_ready) begin
          m_issued = 1;
          if (m_cur == 1 && m_we != 0) m_cur = 0;
        end
      end else if (m_cur == 1) begin
        if (mem_resp_valid) m_cur = 0;
      end else if (mem_resp_valid) begin
        m_left--;
        if (m_left == 0) m_cur = 0;
      end
    end
  endtask

  // Compare process: outputs checked just after each falling edge, model advanced on the rising edge.
  initial begin
    forever begin
      @(negedge clk);
      #1;
      model_expect();
      if (m_known) begin
        chk("ctrl", {25'd0, ctrl_act}, {25'd0, e_crdy, e_grdy, e_mv, e_burst, e_cv, e_gv, e_last});
        chk("mem_req_addr", mem_req_addr, e_addr);
        chk("mem_req_we", {28'd0, mem_req_we}, {28'd0, e_we});
        chk("mem_req_wdata", mem_req_wdata, e_wd);
        chk("cpu_resp_data", cpu_resp_data, e_cd);
        chk("gp_resp_data", gp_resp_data, e_gd);
      end
      @(posedge clk);
      model_step();
    end
  end

  // Stimulus.
  initial begin
    int n;
    bit cpu_acc, gp_acc;
    int pending;
    rst = 1; cpu_req_valid = 0; cpu_req_addr = 0; cpu_req_we = 0; cpu_req_wdata = 0;
    gp_req_valid = 0; gp_req_addr = 0; mem_req_ready = 0; mem_resp_valid = 0; mem_resp_data = 0;
    repeat (3) @(negedge clk);
    rst = 0;
    #2 chk("reset_ctrl", {25'd0, ctrl_act}, 32'd0);

    // CPU read with a stalled accept and delayed response.
    @(negedge clk);
    cpu_req_valid = 1; cpu_req_addr = 32'h1000_0040; cpu_req_we = 4'h0; cpu_req_wdata = 0;
    #2 chk1("t1_cpu_ready", cpu_req_ready, 1'b1);
    @(negedge clk); cpu_req_valid = 0; mem_req_ready = 0;
    #2 chk1("t1_issue_valid", mem_req_valid, 1'b1);
    chk("t1_issue_addr", mem_req_addr, 32'h1000_0040);
    @(negedge clk); mem_req_ready = 1;
    #2 chk("t1_addr_stable", mem_req_addr, 32'h1000_0040);
    @(negedge clk); mem_req_ready = 0;
    #2 chk1("t1_no_resp_yet", cpu_resp_valid, 1'b0);
    @(negedge clk);
    @(negedge clk); mem_resp_valid = 1; mem_resp_data = 32'hDEAD_BEEF;
    #2 chk1("t1_resp_valid", cpu_resp_valid, 1'b1);
    chk("t1_resp_data", cpu_resp_data, 32'hDEAD_BEEF);
    @(negedge clk); mem_resp_valid = 0; mem_resp_data = 0;
    #2 chk1("t1_resp_one_cycle", cpu_resp_valid, 1'b0);

    // CPU write, then simultaneous CPU/GP requests.
    @(negedge clk);
    cpu_req_valid = 1; cpu_req_addr = 32'h0000_0100; cpu_req_we = 4'b0011; cpu_req_wdata = 32'h1234;
    #2 chk1("t2_cpu_ready", cpu_req_ready, 1'b1);
    @(negedge clk); cpu_req_valid = 0; mem_req_ready = 1;
    #2 chk1("t2_mem_valid", mem_req_valid, 1'b1);
    chk("t2_we", {28'd0, mem_req_we}, 32'd3);
    chk("t2_wdata", mem_req_wdata, 32'h1234);
    @(negedge clk); mem_req_ready = 0;
    cpu_req_valid = 1; cpu_req_addr = 32'h0000_0200; cpu_req_we = 4'h0;
    gp_req_valid = 1; gp_req_addr = 32'h1F00_0000;
    #2 chk1("t2_no_resp", cpu_resp_valid, 1'b0);
    chk1("t2_idle_mem", mem_req_valid, 1'b0);
    chk1("t3_cpu_first", cpu_req_ready, 1'b1);
    chk1("t3_gp_held", gp_req_ready, 1'b0);
    @(negedge clk); cpu_req_valid = 0; mem_req_ready = 1;
    #2 chk1("t3_gp_waits", gp_req_ready, 1'b0);
    @(negedge clk); mem_req_ready = 0; mem_resp_valid = 1; mem_resp_data = 32'h0BAD_F00D;
    #2 chk1("t3_cpu_resp", cpu_resp_valid, 1'b1);
    @(negedge clk); mem_resp_valid = 0;
    #2 chk1("t3_gp_granted", gp_req_ready, 1'b1);

    // GP burst with gaps; a CPU write waits for the whole burst.
    @(negedge clk); gp_req_valid = 0; mem_req_ready = 0;
    #2 chk1("t5_burst", mem_req_burst, 1'b1);
    chk("t5_addr", mem_req_addr, 32'h1F00_0000);
    @(negedge clk); mem_req_ready = 1;
    @(negedge clk); mem_req_ready = 0;
    cpu_req_valid = 1; cpu_req_addr = 32'h300; cpu_req_we = 4'hF; cpu_req_wdata = 32'h5555_AAAA;
    for (int i = 0; i < BURST_LEN; i++) begin
      if (i % 3 != 1) begin
        mem_resp_valid = 0;
        #2 chk1("t5_gap", gp_resp_valid, 1'b0);
        @(negedge clk);
      end
      mem_resp_valid = 1; mem_resp_data = 32'(i);
      #2 chk1("t5_beat_valid", gp_resp_valid, 1'b1);
      chk("t5_beat_data", gp_resp_data, 32'(i));
      chk1("t5_last", gp_resp_last, i == BURST_LEN - 1);
      chk1("t5_cpu_waits", cpu_req_ready, 1'b0);
      @(negedge clk);
    end
    mem_resp_valid = 0;
    #2 chk1("t5_cpu_after_burst", cpu_req_ready, 1'b1);
    @(negedge clk); cpu_req_valid = 0; mem_req_ready = 1;
    @(negedge clk); mem_req_ready = 0;

    // Continuous CPU writes starve the GP until the aging limit.
    @(negedge clk);
    gp_req_valid = 1; gp_req_addr = 32'h1F00_0100;
    cpu_req_valid = 1; cpu_req_addr = 32'h400; cpu_req_we = 4'hF; cpu_req_wdata = 32'h77;
    mem_req_ready = 1;
    n = -1;
    for (int c = 0; c < 40; c++) begin
      #2;
      if (gp_req_ready) begin
        n = c;
        break;
      end
      @(negedge clk);
    end
    chk("t4_gp_wait_cycles", 32'(n), 32'(GP_MAX_WAIT));
    @(negedge clk); gp_req_valid = 0;
    #2 chk1("t4_gp_issue", mem_req_burst, 1'b1);
    @(negedge clk); mem_req_ready = 0; cpu_req_valid = 0;
    for (int b = 0; b < BURST_LEN; b++) begin
      mem_resp_valid = 1; mem_resp_data = 32'hA0 + 32'(b);
      @(negedge clk);
    end
    mem_resp_valid = 0;

    // Reset mid-burst abandons the transaction.
    gp_req_valid = 1; gp_req_addr = 32'h1F00_0200;
    #2 chk1("t6_gp_grant", gp_req_ready, 1'b1);
    @(negedge clk); gp_req_valid = 0; mem_req_ready = 1;
    @(negedge clk); mem_req_ready = 0;
    for (int b = 0; b < 4; b++) begin
      mem_resp_valid = 1; mem_resp_data = 32'(b);
      @(negedge clk);
    end
    mem_resp_valid = 0; rst = 1;
    @(negedge clk); rst = 0;
    #2 chk("t6_ctrl_zero", {25'd0, ctrl_act}, 32'd0);
    chk("t6_addr_zero", mem_req_addr, 32'd0);
    for (int b = 0; b < 3; b++) begin
      @(negedge clk); mem_resp_valid = 1; mem_resp_data = 32'hFF;
      #2 chk1("t6_stray_ignored", gp_resp_valid, 1'b0);
    end
    @(negedge clk); mem_resp_valid = 0;

    // Randomized traffic with a responding memory.
    pending = 0; cpu_acc = 0; gp_acc = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      rst = ($urandom_range(0, 599) == 0);
      if (cpu_acc) cpu_req_valid = 0;
      if (gp_acc) gp_req_valid = 0;
      if (!cpu_req_valid && $urandom_range(0, 3) != 0) begin
        cpu_req_valid = 1;
        cpu_req_addr  = $urandom;
        cpu_req_we    = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
        cpu_req_wdata = $urandom;
      end
      if (!gp_req_valid && $urandom_range(0, 2) == 0) begin
        gp_req_valid = 1;
        gp_req_addr  = $urandom & ~32'(BURST_LEN * 4 - 1);
      end
      mem_req_ready = ($urandom_range(0, 1) == 1);
      if (pending > 0 && $urandom_range(0, 2) != 0) begin
        mem_resp_valid = 1; mem_resp_data = $urandom; pending--;
      end else if (pending == 0 && $urandom_range(0, 9) == 0) begin
        mem_resp_valid = 1; mem_resp_data = $urandom;
      end else begin
        mem_resp_valid = 0; mem_resp_data = 0;
      end
      #2;
      cpu_acc = cpu_req_valid && cpu_req_ready;
      gp_acc  = gp_req_valid && gp_req_ready;
      if (rst) pending = 0;
      else if (mem_req_valid && mem_req_ready)
        pending += mem_req_burst ? BURST_LEN : ((mem_req_we == 4'h0) ? 1 : 0);
    end

    @(negedge clk);
    rst = 0; cpu_req_valid = 0; gp_req_valid = 0; mem_resp_valid = 0;
    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
